wrr_lock_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter with packet lock, the successor to the router's plain round-robin arbiter. It is used per output port in the switch allocator. A winner keeps the grant until its tail flit transfers, and it may win up to WEIGHT+1 consecutive packets before priority rotates. Grant is combinational from registered state plus REQ. All state updates happen only on an accepted transfer.

---
 rtl/rtr_arb_pkg.sv | 25 ++
 rtl/rr_prio_pick.sv | 34 +++
 rtl/wrr_lock_arbiter.sv | 117 +++++++++++
 tb/tb_wrr_lock_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rtr_arb_pkg.sv
// Shared types and helpers for the router's switch-allocator arbiters.
package rtr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_st_t;

    localparam int MAXN = 32;
    localparam int MAXW = 5;

    // Index of the first set bit of req[n-1:0], scanning hp, hp+1, ... n-1, 0, ... hp-1; -1 if none.
    function automatic int first_set_rot(input logic [MAXN-1:0] req, input int n, input int hp);
        int idx;
        first_set_rot = -1;
        for (int k = MAXN - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = hp + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAXW-1:0]]) first_set_rot = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: first requester at or after HP wins.
module rr_prio_pick
    import rtr_arb_pkg::*;
#(
    parameter int NR = 5,
    localparam int IDW = $clog2(NR)
) (
    input  logic [NR-1:0]  REQ,
    input  logic [IDW-1:0] HP,
    output logic [NR-1:0]  GNT,
    output logic [IDW-1:0] IDX,
    output logic           VLD
);

    logic [MAXN-1:0] req_ext;
    int              first;

    always_comb begin
        req_ext          = '0;
        req_ext[NR-1:0]  = REQ;
        first            = first_set_rot(req_ext, NR, int'(HP));
        GNT              = '0;
        IDX              = '0;
        VLD              = 1'b0;
        if (first >= 0) begin
            for (int i = 0; i < NR; i++) begin
                if (first == i) GNT[i] = 1'b1;
            end
            IDX = IDW'(first);
            VLD = 1'b1;
        end
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with packet lock; a winner may take WEIGHT+1
// consecutive packets before priority moves on.
module wrr_lock_arbiter
    import rtr_arb_pkg::*;
#(
    parameter int NR = 5,
    parameter int WW = 3,
    localparam int IDW = $clog2(NR)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NR-1:0]    REQ,
    input  logic             EN,
    input  logic             TAIL,
    input  logic [NR*WW-1:0] WEIGHT,
    output logic [NR-1:0]    GRT,
    output logic [IDW-1:0]   GRT_ID,
    output logic             GRT_VLD,
    output logic             LOCKED
);

    arb_st_t        st, st_n;
    logic [IDW-1:0] own, own_n;
    logic [IDW-1:0] hp, hp_n;
    logic [WW-1:0]  cnt, cnt_n;
    logic [WW-1:0]  w_win;
    logic [IDW-1:0] id_inc;
    logic [NR-1:0]  pk_gnt;
    logic [IDW-1:0] pk_id;
    logic           pk_vld;
    logic           xfer;

    rr_prio_pick #(.NR(NR)) u_pick (
        .REQ (REQ),
        .HP  (hp),
        .GNT (pk_gnt),
        .IDX (pk_id),
        .VLD (pk_vld)
    );

    assign LOCKED = (st == LOCK);

    // While locked only the owner can be granted; a dropped owner request stalls.
    always_comb begin
        GRT     = '0;
        GRT_ID  = '0;
        GRT_VLD = 1'b0;
        if (!RST) begin
            if (st == LOCK) begin
                if (REQ[own]) begin
                    GRT[own] = 1'b1;
                    GRT_ID   = own;
                    GRT_VLD  = 1'b1;
                end
            end else begin
                GRT     = pk_gnt;
                GRT_ID  = pk_id;
                GRT_VLD = pk_vld;
            end
        end
    end

    assign xfer   = EN & GRT_VLD;
    assign id_inc = (GRT_ID == IDW'(NR - 1)) ? '0 : GRT_ID + IDW'(1);

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NR; i++) begin
            if (GRT_ID == IDW'(i)) w_win = WEIGHT[i*WW +: WW];
        end
    end

    always_comb begin
        st_n  = st;
        own_n = own;
        hp_n  = hp;
        cnt_n = cnt;
        if (xfer) begin
            if (!TAIL) begin
                st_n  = LOCK;
                own_n = GRT_ID;
            end else begin
                st_n = IDLE;
                if (GRT_ID == hp) begin
                    // A count above a freshly lowered weight ends the streak.
                    if (cnt < w_win) begin
                        cnt_n = cnt + WW'(1);
                    end else begin
                        cnt_n = '0;
                        hp_n  = id_inc;
                    end
                end else if (w_win == '0) begin
                    cnt_n = '0;
                    hp_n  = id_inc;
                end else begin
                    cnt_n = WW'(1);
                    hp_n  = GRT_ID;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st  <= IDLE;
            own <= '0;
            hp  <= '0;
            cnt <= '0;
        end else begin
            st  <= st_n;
            own <= own_n;
            hp  <= hp_n;
            cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter: NR=5 main instance plus NR=3 and NR=8 rotation checks.
module tb_wrr_lock_arbiter;

    logic        CLK;
    logic        rst;

    logic [4:0]  req5, grt5;
    logic        en5, tail5, vld5, locked5;
    logic [14:0] wt5;
    logic [2:0]  id5;

    logic [2:0]  req3, grt3;
    logic        en3, tail3, vld3, locked3;
    logic [8:0]  wt3;
    logic [1:0]  id3;

    logic [7:0]  req8, grt8;
    logic        en8, tail8, vld8, locked8;
    logic [23:0] wt8;
    logic [2:0]  id8;

    int total = 0;
    int bad   = 0;

    wrr_lock_arbiter #(.NR(5), .WW(3)) u5 (
        .CLK(CLK), .RST(rst), .REQ(req5), .EN(en5), .TAIL(tail5), .WEIGHT(wt5),
        .GRT(grt5), .GRT_ID(id5), .GRT_VLD(vld5), .LOCKED(locked5)
    );

    wrr_lock_arbiter #(.NR(3), .WW(3)) u3 (
        .CLK(CLK), .RST(rst), .REQ(req3), .EN(en3), .TAIL(tail3), .WEIGHT(wt3),
        .GRT(grt3), .GRT_ID(id3), .GRT_VLD(vld3), .LOCKED(locked3)
    );

    wrr_lock_arbiter #(.NR(8), .WW(3)) u8 (
        .CLK(CLK), .RST(rst), .REQ(req8), .EN(en8), .TAIL(tail8), .WEIGHT(wt8),
        .GRT(grt8), .GRT_ID(id8), .GRT_VLD(vld8), .LOCKED(locked8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [4:0] rot5 [6];
        logic [2:0] rid5 [6];
        logic [4:0] wseq [8];
        logic [2:0] rot3 [4];
        rot5 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        rid5 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        wseq = '{5'b00010, 5'b00010, 5'b00010, 5'b00100,
                 5'b00010, 5'b00010, 5'b00010, 5'b00100};
        rot3 = '{3'b001, 3'b010, 3'b100, 3'b001};

        rst = 1'b1;
        req5 = 5'b11111; en5 = 1'b1; tail5 = 1'b1; wt5 = '0;
        req3 = '0; en3 = 1'b0; tail3 = 1'b0; wt3 = '0;
        req8 = '0; en8 = 1'b0; tail8 = 1'b0; wt8 = '0;

        // Reset held two cycles: grant forced off
        #1;
        chk("rst_grt", grt5, 0);
        chk("rst_vld", vld5, 0);
        chk("rst_id", id5, 0);
        tick();
        chk("rst_grt2", grt5, 0);
        chk("rst_locked", locked5, 0);
        tick();
        rst = 1'b0;

        // Plain rotation, single-flit packets, weight 0
        for (int k = 0; k < 6; k++) begin
            if (k == 5) en5 = 1'b0;
            #1;
            chk($sformatf("rot_grt%0d", k), grt5, rot5[k]);
            chk($sformatf("rot_id%0d", k), id5, rid5[k]);
            tick();
        end

        // Four-flit packet from requester 0 holds the grant
        req5 = 5'b10001; en5 = 1'b1; tail5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) tail5 = 1'b1;
            #1;
            chk($sformatf("lock_grt%0d", k), grt5, 5'b00001);
            chk($sformatf("lock_locked%0d", k), locked5, (k > 0));
            tick();
        end
        en5 = 1'b0;
        #1;
        chk("unlock_grt", grt5, 5'b10000);
        chk("unlock_locked", locked5, 0);
        tick();

        // Stall inside a lock
        req5 = 5'b00001; en5 = 1'b1; tail5 = 1'b0;
        #1;
        chk("stall_first", grt5, 5'b00001);
        tick();
        req5 = 5'b10001; en5 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("stall_en0_grt%0d", k), grt5, 5'b00001);
            chk($sformatf("stall_en0_lk%0d", k), locked5, 1);
            tick();
        end
        req5 = 5'b10000; en5 = 1'b1;
        #1;
        chk("stall_drop_grt", grt5, 5'b00000);
        chk("stall_drop_vld", vld5, 0);
        chk("stall_drop_lk", locked5, 1);
        tick();
        req5 = 5'b10001; tail5 = 1'b1;
        #1;
        chk("stall_tail_grt", grt5, 5'b00001);
        tick();
        en5 = 1'b0;
        #1;
        chk("stall_rel_lk", locked5, 0);
        chk("stall_rel_grt", grt5, 5'b10000);
        chk("stall_rel_id", id5, 4);
        tick();

        // Weight 2 on requester 1
        wt5 = 15'h0010; req5 = 5'b00110; en5 = 1'b1; tail5 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("wrr_grt%0d", k), grt5, wseq[k]);
            tick();
        end

        // Reset while owner 3 is locked
        wt5 = '0; req5 = 5'b11111; tail5 = 1'b0;
        #1;
        chk("mid_first", grt5, 5'b01000);
        tick();
        #1;
        chk("mid_locked", locked5, 1);
        chk("mid_grt", grt5, 5'b01000);
        rst = 1'b1;
        #1;
        chk("mid_rst_grt", grt5, 0);
        chk("mid_rst_vld", vld5, 0);
        tick();
        rst = 1'b0; en5 = 1'b0;
        #1;
        chk("post_rst_lk", locked5, 0);
        chk("post_rst_grt", grt5, 5'b00001);
        chk("post_rst_id", id5, 0);
        tick();

        // Lone requester is granted every packet
        req5 = 5'b00100; en5 = 1'b1; tail5 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lone_grt%0d", k), grt5, 5'b00100);
            chk($sformatf("lone_id%0d", k), id5, 2);
            tick();
        end
        en5 = 1'b0; req5 = '0;

        // NR=3 rotation with wrap
        req3 = 3'b111; en3 = 1'b1; tail3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("nr3_grt%0d", k), grt3, rot3[k]);
            chk($sformatf("nr3_id%0d", k), id3, k % 3);
            tick();
        end
        en3 = 1'b0;

        // NR=8 rotation with wrap
        req8 = 8'hff; en8 = 1'b1; tail8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("nr8_grt%0d", k), grt8, 32'd1 << (k % 8));
            chk($sformatf("nr8_id%0d", k), id8, k % 8);
            tick();
        end
        en8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
